// File: rtl/if_fetch_queue.sv
// Instruction-fetch front end: owns the fetch PC, issues one request at a time, buffers {inst, pc}.
// Optional IFQ_PERF_EN macro adds perf_fetch_o / perf_drop_o event counters.
module if_fetch_queue #(
    parameter int          DEPTH    = 4,
    parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
    input  logic        clk_i,
    input  logic        rst_i,
    input  logic        start_i,
    output logic        imem_req_o,
    output logic [31:0] imem_addr_o,
    input  logic        imem_ack_i,
    input  logic [31:0] imem_data_i,
    input  logic        stall_i,
    input  logic        redirect_i,
    input  logic [31:0] redirect_pc_i,
`ifdef IFQ_PERF_EN
    output logic [31:0] perf_fetch_o,
    output logic [31:0] perf_drop_o,
`endif
    output logic        valid_o,
    output logic [31:0] inst_o,
    output logic [31:0] pc_o
);

    localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int CW = AW + 1;
    localparam logic [CW-1:0] DEPTH_C = CW'(DEPTH);

    typedef enum logic [1:0] {IDLE, REQ, DROP} state_t;

    state_t         state_q;
    logic           req_q;
    logic [31:0]    addr_q;
    logic [31:0]    fetch_pc_q;
    logic [CW-1:0]  count_q, count_d;
    logic [AW-1:0]  rd_ptr_q, rd_ptr_d;
    logic [AW-1:0]  wr_ptr_q, wr_ptr_d;
    logic [31:0]    inst_mem_q [DEPTH];
    logic [31:0]    pc_mem_q   [DEPTH];

    logic           ack_v;
    logic           push;
    logic           pop;
    logic           can_issue;
    logic [31:0]    redir_pc;
    logic [31:0]    pc_inc;

    // Acks are only meaningful while a request is outstanding.
    assign ack_v     = imem_ack_i & req_q;
    assign redir_pc  = redirect_pc_i & ~32'h3;
    assign pc_inc    = fetch_pc_q + 32'd4;
    assign push      = ack_v && (state_q == REQ) && !redirect_i;
    assign pop       = (count_q != '0) && !stall_i && !redirect_i;
    assign can_issue = (count_d < DEPTH_C);

    always_comb begin
        count_d  = count_q + CW'(push) - CW'(pop);
        rd_ptr_d = rd_ptr_q + AW'(pop);
        wr_ptr_d = wr_ptr_q + AW'(push);
        if (redirect_i) begin
            count_d  = '0;
            rd_ptr_d = '0;
            wr_ptr_d = '0;
        end
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            count_q  <= '0;
            rd_ptr_q <= '0;
            wr_ptr_q <= '0;
            for (int i = 0; i < DEPTH; i++) begin
                inst_mem_q[i] <= '0;
                pc_mem_q[i]   <= '0;
            end
        end else begin
            count_q  <= count_d;
            rd_ptr_q <= rd_ptr_d;
            wr_ptr_q <= wr_ptr_d;
            if (push) begin
                inst_mem_q[wr_ptr_q] <= imem_data_i;
                pc_mem_q[wr_ptr_q]   <= addr_q;
            end
        end
    end

    // Request FSM: address and req are held from issue until the ack cycle.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q    <= IDLE;
            req_q      <= 1'b0;
            addr_q     <= RESET_PC;
            fetch_pc_q <= RESET_PC;
        end else begin
            case (state_q)
                IDLE: begin
                    if (redirect_i) begin
                        fetch_pc_q <= redir_pc;
                    end else if (start_i && can_issue) begin
                        state_q <= REQ;
                        req_q   <= 1'b1;
                        addr_q  <= fetch_pc_q;
                    end
                end
                REQ: begin
                    if (ack_v && redirect_i) begin
                        fetch_pc_q <= redir_pc;
                        if (start_i) begin
                            addr_q <= redir_pc;
                        end else begin
                            state_q <= IDLE;
                            req_q   <= 1'b0;
                        end
                    end else if (ack_v) begin
                        fetch_pc_q <= pc_inc;
                        if (start_i && can_issue) begin
                            addr_q <= pc_inc;
                        end else begin
                            state_q <= IDLE;
                            req_q   <= 1'b0;
                        end
                    end else if (redirect_i) begin
                        fetch_pc_q <= redir_pc;
                        state_q    <= DROP;
                    end
                end
                DROP: begin
                    if (redirect_i) begin
                        fetch_pc_q <= redir_pc;
                    end
                    if (ack_v) begin
                        if (start_i && can_issue) begin
                            state_q <= REQ;
                            addr_q  <= redirect_i ? redir_pc : fetch_pc_q;
                        end else begin
                            state_q <= IDLE;
                            req_q   <= 1'b0;
                        end
                    end
                end
                default: begin
                    state_q <= IDLE;
                    req_q   <= 1'b0;
                end
            endcase
        end
    end

`ifdef IFQ_PERF_EN
    logic [31:0] perf_fetch_q;
    logic [31:0] perf_drop_q;
    logic        discard;

    // Discarded responses plus whatever a redirect throws out of the buffer.
    assign discard = ack_v && ((state_q == DROP) || redirect_i);

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            perf_fetch_q <= '0;
            perf_drop_q  <= '0;
        end else begin
            perf_fetch_q <= perf_fetch_q + 32'(push);
            perf_drop_q  <= perf_drop_q + 32'(discard) + (redirect_i ? 32'(count_q) : 32'd0);
        end
    end

    assign perf_fetch_o = perf_fetch_q;
    assign perf_drop_o  = perf_drop_q;
`endif

    assign imem_req_o  = req_q;
    assign imem_addr_o = addr_q;
    assign valid_o     = (count_q != '0);
    assign inst_o      = inst_mem_q[rd_ptr_q];
    assign pc_o        = pc_mem_q[rd_ptr_q];

endmodule

// File: tb/tb_if_fetch_queue.sv
// Scoreboard bench for if_fetch_queue: variable-latency memory model plus expected {pc, inst} queue.
module tb_if_fetch_queue;

    localparam logic [31:0] RESET_PC = 32'h0000_0000;

    logic        clk = 1'b0;
    logic        rst_i = 1'b1;
    logic        start_i = 1'b0;
    logic        imem_req_o;
    logic [31:0] imem_addr_o;
    logic        imem_ack_i = 1'b0;
    logic [31:0] imem_data_i = '0;
    logic        stall_i = 1'b0;
    logic        redirect_i = 1'b0;
    logic [31:0] redirect_pc_i = '0;
    logic        valid_o;
    logic [31:0] inst_o;
    logic [31:0] pc_o;
`ifdef IFQ_PERF_EN
    logic [31:0] perf_fetch_o;
    logic [31:0] perf_drop_o;
`endif

    if_fetch_queue #(.DEPTH(4), .RESET_PC(RESET_PC)) dut (
        .clk_i        (clk),
        .rst_i        (rst_i),
        .start_i      (start_i),
        .imem_req_o   (imem_req_o),
        .imem_addr_o  (imem_addr_o),
        .imem_ack_i   (imem_ack_i),
        .imem_data_i  (imem_data_i),
        .stall_i      (stall_i),
        .redirect_i   (redirect_i),
        .redirect_pc_i(redirect_pc_i),
`ifdef IFQ_PERF_EN
        .perf_fetch_o (perf_fetch_o),
        .perf_drop_o  (perf_drop_o),
`endif
        .valid_o      (valid_o),
        .inst_o       (inst_o),
        .pc_o         (pc_o)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [31:0] pc;
        logic [31:0] inst;
    } entry_t;

    entry_t      sb_q[$];
    int          checks = 0;
    int          errors = 0;
    int          lat = 1;
    int          wait_cnt = 0;
    int          pushes = 0;
    logic [31:0] exp_pc = RESET_PC;
    logic        drop_pending = 1'b0;
    logic        prev_hold = 1'b0;
    logic [31:0] prev_addr = '0;

    function automatic logic [31:0] inst_of(input logic [31:0] a);
        return {a[15:0], a[31:16]} ^ 32'hDEAD_BEEF;
    endfunction

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        if (obs !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%08h want 0x%08h", tag, obs, exp);
        end
    endtask

    task automatic do_reset();
        @(posedge clk); #1;
        rst_i = 1'b1; start_i = 1'b0; stall_i = 1'b0; redirect_i = 1'b0; imem_ack_i = 1'b0;
        @(posedge clk); #1;
        rst_i = 1'b0;
        sb_q.delete();
        exp_pc = RESET_PC; drop_pending = 1'b0; wait_cnt = 0; prev_hold = 1'b0;
        check("rst_valid", {31'd0, valid_o}, 32'd0);
        check("rst_inst", inst_o, 32'd0);
        check("rst_pc", pc_o, 32'd0);
        check("rst_req", {31'd0, imem_req_o}, 32'd0);
        check("rst_addr", imem_addr_o, RESET_PC);
    endtask

    // One clock: memory responds, outputs are checked against the model, model advances.
    task automatic cyc(input logic st, input logic stl, input logic rd, input logic [31:0] rpc);
        logic ack;
        @(posedge clk); #1;
        start_i = st; stall_i = stl; redirect_i = rd; redirect_pc_i = rpc;
        ack = 1'b0;
        if (imem_req_o) begin
            wait_cnt++;
            if (wait_cnt >= lat) begin
                ack = 1'b1;
                wait_cnt = 0;
            end
        end
        imem_ack_i  = ack;
        imem_data_i = ack ? inst_of(imem_addr_o) : 32'h0BAD_F00D;
        if (prev_hold) check("addr_hold", imem_addr_o, prev_addr);
        prev_hold = imem_req_o && !ack;
        prev_addr = imem_addr_o;
        check("valid", {31'd0, valid_o}, {31'd0, sb_q.size() != 0});
        if (sb_q.size() != 0) begin
            check("head_pc", pc_o, sb_q[0].pc);
            check("head_inst", inst_o, sb_q[0].inst);
        end
        if (rd) begin
            if (imem_req_o && !ack) drop_pending = 1'b1;
            else if (ack) drop_pending = 1'b0;
            sb_q.delete();
            exp_pc = rpc & ~32'h3;
        end else begin
            if (sb_q.size() != 0 && !stl) void'(sb_q.pop_front());
            if (ack) begin
                if (drop_pending) begin
                    drop_pending = 1'b0;
                end else begin
                    check("req_addr", imem_addr_o, exp_pc);
                    sb_q.push_back('{pc: exp_pc, inst: inst_of(exp_pc)});
                    pushes++;
                    exp_pc = exp_pc + 32'd4;
                end
            end
        end
    endtask

    task automatic run(input int n, input logic stl);
        for (int i = 0; i < n; i++) cyc(1'b1, stl, 1'b0, '0);
    endtask

    initial begin
        logic found;

        // Back-to-back fetch with single-cycle memory
        do_reset();
`ifdef IFQ_PERF_EN
        check("perf_fetch_rst", perf_fetch_o, 32'd0);
        check("perf_drop_rst", perf_drop_o, 32'd0);
`endif
        lat = 1;
        run(12, 1'b0);
`ifdef IFQ_PERF_EN
        check("perf_fetch_cnt", perf_fetch_o, 32'(pushes));
`endif

        // Stall until full, then drain
        do_reset();
        run(10, 1'b1);
        check("full_entries", 32'(sb_q.size()), 32'd4);
        check("full_req_low", {31'd0, imem_req_o}, 32'd0);
        run(14, 1'b0);

        // Slow memory, redirect while the 0x8 request is outstanding
        do_reset();
        lat = 3;
        found = 1'b0;
        for (int i = 0; i < 20 && !found; i++) begin
            cyc(1'b1, 1'b0, 1'b0, '0);
            if (imem_req_o && imem_addr_o == 32'h8) found = 1'b1;
        end
        check("saw_req_8", {31'd0, found}, 32'd1);
        cyc(1'b1, 1'b0, 1'b1, 32'h100);
        run(16, 1'b0);

        // Redirect coinciding with an ack, misaligned target
        do_reset();
        lat = 1;
        run(4, 1'b0);
        check("req_before_redir", {31'd0, imem_req_o}, 32'd1);
        cyc(1'b1, 1'b0, 1'b1, 32'h41);
        @(posedge clk); #1;
        check("flush_valid", {31'd0, valid_o}, 32'd0);
        check("redir_req", {31'd0, imem_req_o}, 32'd1);
        check("redir_addr", imem_addr_o, 32'h40);
        prev_hold = 1'b0;
        wait_cnt = 0;
        run(6, 1'b0);

        // Two entries buffered, then simultaneous push/pop; then PC wrap
        do_reset();
        run(3, 1'b1);
        run(6, 1'b0);
        cyc(1'b1, 1'b0, 1'b1, 32'hFFFF_FFFC);
        run(8, 1'b0);

        // Reset while dropping an outstanding response
        do_reset();
        lat = 5;
        found = 1'b0;
        for (int i = 0; i < 10 && !found; i++) begin
            cyc(1'b1, 1'b0, 1'b0, '0);
            if (imem_req_o) found = 1'b1;
        end
        check("saw_req_drop", {31'd0, found}, 32'd1);
        cyc(1'b1, 1'b0, 1'b1, 32'h200);
        cyc(1'b1, 1'b0, 1'b0, '0);
        do_reset();
`ifdef IFQ_PERF_EN
        check("perf_fetch_rst2", perf_fetch_o, 32'd0);
        check("perf_drop_rst2", perf_drop_o, 32'd0);
`endif
        imem_ack_i = 1'b1;
        imem_data_i = 32'hBAD0_BAD0;
        @(posedge clk); #1;
        imem_ack_i = 1'b0;
        check("late_ack_valid", {31'd0, valid_o}, 32'd0);
        check("late_ack_req", {31'd0, imem_req_o}, 32'd0);
        check("late_ack_addr", imem_addr_o, RESET_PC);
        lat = 1;
        run(8, 1'b0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
